// File: rtl/respawn_timer.sv
// Per-player death/respawn sequencer: retrigger, cancel, global pause, one-cycle respawn pulse.
// Optional invulnerability window after respawn is compiled in with RESPAWN_INVULN_EN.
module respawn_timer #(
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 27,
    parameter int DEAD_CYCLES   = 134217700,
    parameter int INVULN_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] kill,
    input  logic [NUM_CH-1:0] cancel,
    input  logic              pause,
    output logic [NUM_CH-1:0] death,
    output logic [NUM_CH-1:0] respawn_pulse,
`ifdef RESPAWN_INVULN_EN
    output logic [NUM_CH-1:0] invuln,
`endif
    output logic              any_dead
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef RESPAWN_INVULN_EN
        ST_INVULN = 2'd2,
`endif
        ST_DEAD   = 2'd1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
`ifdef RESPAWN_INVULN_EN
    localparam logic [CNT_W-1:0] INV_LAST  = CNT_W'(INVULN_CYCLES - 1);
    localparam state_t           ST_EXPIRY = ST_INVULN;
`else
    localparam state_t           ST_EXPIRY = ST_IDLE;
`endif

    state_t            state_r [NUM_CH];
    state_t            state_s [NUM_CH];
    logic [CNT_W-1:0]  count_r [NUM_CH];
    logic [CNT_W-1:0]  count_s [NUM_CH];
    logic [NUM_CH-1:0] death_s;
    logic [NUM_CH-1:0] pulse_s;
    logic [NUM_CH-1:0] death_r;
    logic [NUM_CH-1:0] pulse_r;
    logic              any_dead_r;
`ifdef RESPAWN_INVULN_EN
    logic [NUM_CH-1:0] invuln_s;
    logic [NUM_CH-1:0] invuln_r;
`endif

    // Next-state and next-output logic for every channel; priority cancel > kill > pause > count.
    always_comb begin
        death_s = {NUM_CH{1'b0}};
        pulse_s = {NUM_CH{1'b0}};
`ifdef RESPAWN_INVULN_EN
        invuln_s = {NUM_CH{1'b0}};
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_s[ch] = state_r[ch];
            count_s[ch] = count_r[ch];
            case (state_r[ch])
                ST_IDLE: begin
                    count_s[ch] = CNT_ZERO;
                    if (kill[ch] && !cancel[ch]) begin
                        state_s[ch] = ST_DEAD;
                    end else begin
                        state_s[ch] = ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    if (cancel[ch]) begin
                        state_s[ch] = ST_IDLE;
                        count_s[ch] = CNT_ZERO;
                    end else if (kill[ch]) begin
                        count_s[ch] = CNT_ZERO;
                    end else if (pause) begin
                        count_s[ch] = count_r[ch];
                    end else if (count_r[ch] == DEAD_LAST) begin
                        // The compare stops the counter here, so it can never wrap.
                        state_s[ch] = ST_EXPIRY;
                        count_s[ch] = CNT_ZERO;
                        pulse_s[ch] = 1'b1;
                    end else begin
                        count_s[ch] = count_r[ch] + CNT_ONE;
                    end
                end
`ifdef RESPAWN_INVULN_EN
                ST_INVULN: begin
                    if (cancel[ch]) begin
                        state_s[ch] = ST_IDLE;
                        count_s[ch] = CNT_ZERO;
                    end else if (pause) begin
                        count_s[ch] = count_r[ch];
                    end else if (count_r[ch] == INV_LAST) begin
                        state_s[ch] = ST_IDLE;
                        count_s[ch] = CNT_ZERO;
                    end else begin
                        count_s[ch] = count_r[ch] + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_s[ch] = ST_IDLE;
                    count_s[ch] = CNT_ZERO;
                end
            endcase
            death_s[ch] = (state_s[ch] == ST_DEAD);
`ifdef RESPAWN_INVULN_EN
            invuln_s[ch] = (state_s[ch] == ST_INVULN);
`endif
        end
    end

    // State, counters and registered outputs; any_dead comes from the next-state vector to stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_r[ch] <= ST_IDLE;
                count_r[ch] <= CNT_ZERO;
            end
            death_r    <= {NUM_CH{1'b0}};
            pulse_r    <= {NUM_CH{1'b0}};
            any_dead_r <= 1'b0;
`ifdef RESPAWN_INVULN_EN
            invuln_r   <= {NUM_CH{1'b0}};
`endif
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_r[ch] <= state_s[ch];
                count_r[ch] <= count_s[ch];
            end
            death_r    <= death_s;
            pulse_r    <= pulse_s;
            any_dead_r <= |death_s;
`ifdef RESPAWN_INVULN_EN
            invuln_r   <= invuln_s;
`endif
        end
    end

    assign death         = death_r;
    assign respawn_pulse = pulse_r;
    assign any_dead      = any_dead_r;
`ifdef RESPAWN_INVULN_EN
    assign invuln        = invuln_r;
`endif

endmodule

// File: tb/tb_respawn_timer.sv
// Bench for respawn_timer: directed literal scenarios plus randomized traffic against a countdown model.
// Honours RESPAWN_INVULN_EN when the design is built with it.
module tb_respawn_timer;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 5;
    localparam int DEAD   = 10;
    localparam int INV    = 4;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] kill;
    logic [NUM_CH-1:0] cancel;
    logic              pause;
    logic [NUM_CH-1:0] death;
    logic [NUM_CH-1:0] respawn_pulse;
    logic              any_dead;
`ifdef RESPAWN_INVULN_EN
    logic [NUM_CH-1:0] invuln;
`endif

    int tests;
    int fails;
    int cyc;
    bit run_chk;

    // Model: remaining dead cycles and remaining invulnerable cycles per channel.
    int   m_rem [NUM_CH];
    int   m_inv [NUM_CH];
    logic [NUM_CH-1:0] m_pulse;

    respawn_timer #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEAD_CYCLES(DEAD), .INVULN_CYCLES(INV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kill(kill),
        .cancel(cancel),
        .pause(pause),
        .death(death),
        .respawn_pulse(respawn_pulse),
`ifdef RESPAWN_INVULN_EN
        .invuln(invuln),
`endif
        .any_dead(any_dead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s t=%0t cyc=%0d got=%0d exp=%0d", name, $time, cyc, got, exp);
        end
    endtask

    // Reference model: a kill (re)arms a DEAD-cycle countdown; the last tick fires the pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_rem[ch]   <= 0;
                m_inv[ch]   <= 0;
                m_pulse[ch] <= 1'b0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_pulse[ch] <= 1'b0;
                if (cancel[ch]) begin
                    m_rem[ch] <= 0;
                    m_inv[ch] <= 0;
                end else if (m_rem[ch] > 0) begin
                    if (kill[ch]) m_rem[ch] <= DEAD;
                    else if (pause) m_rem[ch] <= m_rem[ch];
                    else if (m_rem[ch] == 1) begin
                        m_rem[ch]   <= 0;
                        m_pulse[ch] <= 1'b1;
`ifdef RESPAWN_INVULN_EN
                        m_inv[ch]   <= INV;
`endif
                    end else m_rem[ch] <= m_rem[ch] - 1;
                end else if (m_inv[ch] > 0) begin
                    if (!pause) m_inv[ch] <= m_inv[ch] - 1;
                end else if (kill[ch]) begin
                    m_rem[ch] <= DEAD;
                end
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (run_chk) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                chk($sformatf("model_death%0d", ch), int'(death[ch]), int'(m_rem[ch] > 0));
                chk($sformatf("model_pulse%0d", ch), int'(respawn_pulse[ch]), int'(m_pulse[ch]));
`ifdef RESPAWN_INVULN_EN
                chk($sformatf("model_invuln%0d", ch), int'(invuln[ch]), int'(m_inv[ch] > 0));
`endif
            end
            chk("model_any_dead", int'(any_dead), int'((m_rem[0] > 0) || (m_rem[1] > 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        kill   = '0;
        cancel = '0;
        pause  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        cyc = 0;
    endtask

    // Hand-computed waveforms for the directed scenarios (cycle numbers as in the test plan).
    task automatic check_scn(input int id, input int c);
        bit d0, d1, p0, p1, i0;
        d0 = 1'b0; d1 = 1'b0; p0 = 1'b0; p1 = 1'b0; i0 = 1'b0;
        case (id)
            0: begin d0 = (c >= 6 && c <= 15); p0 = (c == 16); end
            1: begin d0 = (c >= 6 && c <= 20); p0 = (c == 21); end
            2: begin d0 = (c >= 6 && c <= 20); p0 = (c == 21); end
            3: begin d1 = (c >= 6 && c <= 9); end
            default: begin d0 = (c >= 6 && c <= 15); p0 = (c == 16); i0 = (c >= 16 && c <= 19); end
        endcase
        chk($sformatf("s%0d_death0", id), int'(death[0]), int'(d0));
        chk($sformatf("s%0d_death1", id), int'(death[1]), int'(d1));
        chk($sformatf("s%0d_pulse0", id), int'(respawn_pulse[0]), int'(p0));
        chk($sformatf("s%0d_pulse1", id), int'(respawn_pulse[1]), int'(p1));
        chk($sformatf("s%0d_any_dead", id), int'(any_dead), int'(d0 | d1));
`ifdef RESPAWN_INVULN_EN
        chk($sformatf("s%0d_invuln0", id), int'(invuln[0]), int'(i0));
`else
        if (i0) chk("s_invuln_unexpected", 1, 0);
`endif
    endtask

    task automatic drive_scn(input int id, input int c);
        kill   = '0;
        cancel = '0;
        pause  = 1'b0;
        case (id)
            0: kill[0] = (c == 5);
            1: kill[0] = (c == 5 || c == 10);
            2: begin kill[0] = (c == 5); pause = (c >= 8 && c <= 12); end
            3: begin kill[1] = (c == 5); cancel[1] = (c == 9); end
            default: kill[0] = (c == 5 || c == 17);
        endcase
    endtask

    task automatic run_scn(input int id);
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            check_scn(id, cyc);
            drive_scn(id, cyc);
            tick();
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; run_chk = 1'b0;
        reset = 1'b1; kill = '0; cancel = '0; pause = 1'b0;
        #2;
        chk("reset_death", int'(death), 0);
        chk("reset_pulse", int'(respawn_pulse), 0);
        chk("reset_any_dead", int'(any_dead), 0);
        tick();
        reset = 1'b0;
        tick();
        run_chk = 1'b1;

        for (int id = 0; id < 4; id++) run_scn(id);
`ifdef RESPAWN_INVULN_EN
        run_scn(5);
`endif

        // Asynchronous reset mid-window aborts both channels silently.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c >= 6) chk("rst_pre_death", int'(death), 3);
            kill = (cyc == 5) ? 2'b11 : 2'b00;
            tick();
        end
        kill = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_death", int'(death), 0);
        chk("rst_async_pulse", int'(respawn_pulse), 0);
        chk("rst_async_any_dead", int'(any_dead), 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 14; c++) begin
            chk("rst_after_death", int'(death), 0);
            chk("rst_after_pulse", int'(respawn_pulse), 0);
            chk("rst_after_any", int'(any_dead), 0);
            tick();
        end

        // Randomized traffic, including held kills and occasional synchronous-looking resets.
        for (int n = 0; n < 4000; n++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                kill[ch]   = ($urandom_range(0, 13) == 0) || (n >= 2000 && n < 2040 && ch == 0);
                cancel[ch] = ($urandom_range(0, 40) == 0);
            end
            pause = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 600) == 0);
            tick();
        end
        reset = 1'b0;
        kill = '0; cancel = '0; pause = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/respawn_timer.md
Name: respawn_timer

Overview:
- Multi-channel successor of the single-player death timer.
- One independent death/respawn sequencer per player, with a parametrised duration and counter width.
- Adds retrigger, cancel, a global pause, and a one-cycle respawn pulse per channel.
- Sits between collision/hit detection and the player-control and sprite logic. death masks player input; respawn_pulse triggers repositioning.

Parameters:
- NUM_CH, 2: number of independent channels (players).
- CNT_W, 27: per-channel counter width in bits.
- DEAD_CYCLES, 134217700: length of the death window in clk cycles. Legal range is 1 to 2^CNT_W-1; other values are a configuration error.
- INVULN_CYCLES, 50000000: invulnerability window length. Used only with the optional feature; same legal range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all channels immediately.
- kill  in  NUM_CH  per-channel hit strobe (level-sampled each cycle).
- cancel  in  NUM_CH  per-channel abort, e.g. on round restart; overrides kill.
- pause  in  1  global freeze of all counters.
- death  out  NUM_CH  channel is dead.
- respawn_pulse  out  NUM_CH  one-cycle strobe on normal expiry of the death window.
- any_dead  out  1  OR of death, registered.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is high, every channel is IDLE, count=0, and death, respawn_pulse and any_dead are 0.
- Per-channel state machine, all outputs registered.
  - IDLE (death=0): kill=1 and cancel=0 -> DEAD with count=0.
  - DEAD (death=1):
    - cancel=1 -> IDLE, count=0, no respawn_pulse.
    - Else kill=1 -> stay DEAD, count reloads to 0 (retrigger extends the window; pause does not block the reload).
    - Else pause=1 -> hold count.
    - Else count==DEAD_CYCLES-1 -> IDLE (or INVULN if the feature is compiled in), count=0, respawn_pulse=1 for one cycle.
    - Else count+1.
- Latency: kill sampled at edge k -> death high from k (visible in cycle k+1).
- Window length: a single-cycle kill with no pause or retrigger gives death high for exactly DEAD_CYCLES cycles.
- Pulse timing: respawn_pulse rises on the same edge that death falls.
- Priority per channel: reset > cancel > kill > pause > count.
- Channels are fully independent; simultaneous kills on several channels are each handled the same cycle.
- any_dead is registered from the next-state death vector, so it is cycle-aligned with death.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the expiry compare stops it at DEAD_CYCLES-1.
- Reset mid-window aborts silently: no respawn_pulse.
- Kill held continuously keeps the channel in DEAD indefinitely. Expiry starts only after kill falls.

Optional Feature:
- Macro: RESPAWN_INVULN_EN.
- Defined:
  - Adds per-channel state INVULN and output port invuln [NUM_CH], reset value 0.
  - Expiry from DEAD enters INVULN: invuln=1, death=0, count restarts at 0.
  - In INVULN, kill is ignored. pause holds count. cancel -> IDLE.
  - At count==INVULN_CYCLES-1 -> IDLE, invuln=0.
  - respawn_pulse is still issued when entering INVULN.
- Undefined:
  - No INVULN state and no invuln port. Expiry goes straight to IDLE.
  - INVULN_CYCLES is unused.

Test Plan (DEAD_CYCLES=10, INVULN_CYCLES=4, CNT_W=5, NUM_CH=2):
- One-cycle kill[0] at cycle 5 -> death[0] high cycles 6-15; respawn_pulse[0] high cycle 16 only; death[1]=0 throughout; any_dead tracks death[0].
- kill[0] pulses at cycles 5 and 10 -> death[0] high cycles 6-20; exactly one respawn_pulse[0], at cycle 21.
- kill[0] at 5, pause high cycles 8-12 -> death[0] high cycles 6-20; respawn_pulse at 21.
- kill[1] at 5, cancel[1] at 9 -> death[1] falls at cycle 10; no respawn_pulse[1].
- kill[0] and kill[1] both at 5, reset asserted asynchronously mid-cycle 8 -> death, any_dead and respawn_pulse go to 0 immediately and stay 0 after release.
- With RESPAWN_INVULN_EN: kill[0] at 5 -> invuln[0] high cycles 16-19; a kill[0] at 17 is ignored; death[0] stays 0 after cycle 15.
